t_counter: RTL and testbench
============================

Name: t_counter

Overview:
- Parametrised synchronous up/down counter built from per-bit T flip-flop cells.
- Generalises the single toggle flip-flop to WIDTH bits, adding:
  - count enable and direction control
  - synchronous parallel load
  - a programmable modulus (MAX_COUNT)
  - wrap or saturate mode at the boundaries
- Used as the general event/timer counter in later lab blocks (dividers, sequence timers).

Parameters:
- WIDTH, 4, counter width in bits (legal range 2..16).
- MAX_COUNT, 2**WIDTH-1, terminal value; count range is 0..MAX_COUNT (must be ≤ 2**WIDTH-1 and ≥ 1).
- SATURATE, 0, 0 = wrap at boundaries; 1 = hold at boundaries.

Ports:
- clk, input, 1, single clock; all state updates on the rising edge.
- reset, input, 1, asynchronous, active-high reset.
- en, input, 1, count enable; counter advances one step per enabled cycle.
- up_dn, input, 1, direction: 1 = up, 0 = down.
- load, input, 1, synchronous parallel load request.
- load_val, input, WIDTH, value loaded when load = 1.
- q, output, WIDTH, current count (registered).
- tc, output, 1, terminal count, combinational from q and up_dn: q == MAX_COUNT when up_dn = 1, q == 0 when up_dn = 0.
- wrap, output, 1, registered one-cycle pulse, high in the cycle after a boundary crossing occurred.
- sat, output, 1, registered level, high while a saturate-mode count request is being blocked at a boundary.

Behaviour:
- Reset (asynchronous, active-high):
  - q = 0, wrap = 0, sat = 0 immediately, independent of clk.
  - tc follows q (so tc = 1 if up_dn = 0).
- Reset release: the first update occurs at the first rising edge with reset low. No count happens on the release edge itself unless that edge is a normal rising edge with reset already deasserted.
- Per-edge priority: reset > load > en > hold.
- Load:
  - q <= load_val when load_val ≤ MAX_COUNT; otherwise q <= MAX_COUNT (clamp).
  - wrap <= 0, sat <= 0.
  - Load overrides en in the same cycle.
- Count, normal step (not at a boundary):
  - Up: q <= q + 1. Down: q <= q - 1.
  - Realised as per-bit toggle enables. Bit i toggles when en = 1 and all bits below i are 1 (up) or 0 (down); bit 0 toggles on every enabled step.
  - wrap <= 0, sat <= 0.
- Up at q == MAX_COUNT:
  - SATURATE = 0: q <= 0, wrap <= 1 for exactly one cycle.
  - SATURATE = 1: q holds, sat <= 1, wrap stays 0.
- Down at q == 0:
  - SATURATE = 0: q <= MAX_COUNT, wrap <= 1.
  - SATURATE = 1: q holds, sat <= 1.
- Boundary forcing: the boundary targets (0 or MAX_COUNT) are forced through the cells' synchronous load path, not the toggle path. This is required when MAX_COUNT is not all-ones.
- Idle (en = 0, load = 0): q holds, wrap <= 0, sat <= 0.
- Direction change mid-count: takes effect on the next enabled edge; no penalty cycle. tc re-evaluates combinationally on the up_dn change.
- Back-to-back wraps: continuous en at a boundary every cycle produces wrap high on each crossing. With MAX_COUNT = 1, up-counting with en held asserted gives wrap asserted on every second cycle.
- Latency: q changes one clock after the qualifying edge inputs; wrap/sat align with the q update.
- Illegal state (q > MAX_COUNT, reachable only by X or a glitch): the next enabled or idle edge is not required to recover it; load or reset recovers.

Decomposition:
- Shared package t_counter_pkg:
  - localparam encodings DIR_UP = 1'b1, DIR_DN = 1'b0
  - mode constants MODE_WRAP = 0, MODE_SAT = 1
  - function clamp_load(val, max)
- Sub-module t_ff_cell: one bit with ports clk, reset, t, ld, d, q. ld has priority over t; asynchronous active-high reset to 0. Instantiated WIDTH times via generate.
- Toggle-enable chain, boundary detect and flag registers live in t_counter.

Test Plan (WIDTH = 4, MAX_COUNT = 9 unless noted):
- Reset mid-count: count to 5, assert reset between edges → q = 0, wrap = 0, sat = 0 immediately. Release → next enabled up edge gives q = 1.
- Up wrap (SATURATE = 0): load 7, en = 1, up_dn = 1 for 4 cycles → q = 8, 9, 0, 1. wrap is high only in the cycle q = 0. tc is high while q = 9.
- Down wrap: load 1, up_dn = 0, en 3 cycles → q = 0, 9, 8. wrap is high in the cycle q = 9. tc is high while q = 0.
- Saturate (SATURATE = 1): load 8, up 3 cycles → q = 9, 9, 9, with sat high for the last two cycles. Then up_dn = 0 → q = 8, sat = 0.
- Load priority and clamp: load = 1 with load_val = 13 and en = 1 → q = 9 (not 10 or 0). Next, load_val = 3 with load = 1 → q = 3.
- Full-range toggle chain (WIDTH = 4, MAX_COUNT = 15): up count from 0 for 16 cycles → every value 0..15 appears in order, then 0 with wrap. Idle cycles inserted in between hold q.

Source files
------------

// File: rtl/t_counter_pkg.sv
// Shared constants and helpers for the T-flip-flop based up/down counter.
package t_counter_pkg;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

  localparam int MODE_WRAP = 0;
  localparam int MODE_SAT  = 1;

  // Limit a requested load value to the counter's terminal value.
  function automatic logic [15:0] clamp_load(input logic [15:0] val, input logic [15:0] max);
    logic [15:0] res;
    if (val > max) begin
      res = max;
    end else begin
      res = val;
    end
    return res;
  endfunction

endpackage

// File: rtl/t_counter_t_ff_cell.sv
// One counter bit: T flip-flop with a synchronous load path that wins over toggle.
module t_ff_cell (
  input  logic clk,
  input  logic reset,
  input  logic t,
  input  logic ld,
  input  logic d,
  output logic q
);

  // Bit state: async clear, then load, then toggle, else hold.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= 1'b0;
    end else if (ld) begin
      q <= d;
    end else if (t) begin
      q <= ~q;
    end else begin
      q <= q;
    end
  end

endmodule

// File: rtl/t_counter.sv
// WIDTH-bit up/down counter with programmable modulus, built from T flip-flop
// cells; boundary targets go through the cells' load path so any MAX_COUNT works.
module t_counter
  import t_counter_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int MAX_COUNT = 2**WIDTH - 1,
  parameter int SATURATE  = MODE_WRAP
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrap,
  output logic             sat
);

  localparam logic [WIDTH-1:0] MAX_V    = WIDTH'(MAX_COUNT);
  localparam logic [WIDTH-1:0] ZERO_V   = {WIDTH{1'b0}};
  localparam logic             SAT_MODE = (SATURATE == MODE_SAT);

  logic             at_max_s;
  logic             at_zero_s;
  logic             hit_s;
  logic             ld_all_s;
  logic [WIDTH-1:0] chain_s;
  logic [WIDTH-1:0] t_s;
  logic [WIDTH-1:0] d_s;

  assign at_max_s  = (q == MAX_V);
  assign at_zero_s = (q == ZERO_V);
  assign tc        = (up_dn == DIR_UP) ? at_max_s : at_zero_s;
  // A count request that lands on the boundary in the current direction.
  assign hit_s     = en & ~load & tc;

  // Ripple toggle-enable chain: bit i toggles when all lower bits are 1 (up) or 0 (down).
  always_comb begin
    chain_s    = ZERO_V;
    chain_s[0] = 1'b1;
    for (int i = 1; i < WIDTH; i++) begin
      chain_s[i] = chain_s[i-1] & ((up_dn == DIR_UP) ? q[i-1] : ~q[i-1]);
    end
  end

  // Cell control: load and boundary wrap use the load path, normal steps toggle.
  always_comb begin
    ld_all_s = 1'b0;
    d_s      = ZERO_V;
    t_s      = ZERO_V;
    if (load) begin
      ld_all_s = 1'b1;
      d_s      = WIDTH'(clamp_load(16'(load_val), 16'(MAX_COUNT)));
    end else if (hit_s) begin
      if (SAT_MODE) begin
        t_s = ZERO_V;
      end else begin
        ld_all_s = 1'b1;
        d_s      = (up_dn == DIR_UP) ? ZERO_V : MAX_V;
      end
    end else if (en) begin
      t_s = chain_s;
    end else begin
      t_s = ZERO_V;
    end
  end

  for (genvar g = 0; g < WIDTH; g++) begin : g_cell
    t_ff_cell u_cell (
      .clk  (clk),
      .reset(reset),
      .t    (t_s[g]),
      .ld   (ld_all_s),
      .d    (d_s[g]),
      .q    (q[g])
    );
  end

  // Boundary flags, aligned with the q update they describe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wrap <= 1'b0;
      sat  <= 1'b0;
    end else if (hit_s) begin
      wrap <= ~SAT_MODE;
      sat  <= SAT_MODE;
    end else begin
      wrap <= 1'b0;
      sat  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_t_counter.sv
// Self-checking bench: three counter configurations share one stimulus stream
// and are compared against an arithmetic reference model.
module tb_t_counter;

  logic       clk;
  logic       reset;
  logic       en;
  logic       up_dn;
  logic       load;
  logic [3:0] load_val;

  logic [3:0] dq [3];
  logic       dtc[3];
  logic       dw [3];
  logic       ds [3];

  int mq[3];
  int mw[3];
  int ms[3];
  int mx[3]   = '{9, 9, 15};
  int msat[3] = '{0, 1, 0};

  int compared = 0;
  int failed   = 0;

  // index 0: MAX 9 wrap, 1: MAX 9 saturate, 2: MAX 15 wrap
  t_counter #(.WIDTH(4), .MAX_COUNT(9), .SATURATE(0)) u_w (
    .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .load(load), .load_val(load_val),
    .q(dq[0]), .tc(dtc[0]), .wrap(dw[0]), .sat(ds[0]));
  t_counter #(.WIDTH(4), .MAX_COUNT(9), .SATURATE(1)) u_s (
    .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .load(load), .load_val(load_val),
    .q(dq[1]), .tc(dtc[1]), .wrap(dw[1]), .sat(ds[1]));
  t_counter #(.WIDTH(4), .MAX_COUNT(15), .SATURATE(0)) u_f (
    .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .load(load), .load_val(load_val),
    .q(dq[2]), .tc(dtc[2]), .wrap(dw[2]), .sat(ds[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      mq[i] = 0; mw[i] = 0; ms[i] = 0;
    end
  endtask

  // Reference rules: load clamps, counting steps by one, boundaries wrap or hold.
  task automatic model_step();
    for (int i = 0; i < 3; i++) begin
      mw[i] = 0; ms[i] = 0;
      if (load) begin
        mq[i] = (int'(load_val) > mx[i]) ? mx[i] : int'(load_val);
      end else if (en) begin
        if (up_dn) begin
          if (mq[i] == mx[i]) begin
            if (msat[i] == 1) ms[i] = 1;
            else begin mq[i] = 0; mw[i] = 1; end
          end else mq[i] = mq[i] + 1;
        end else begin
          if (mq[i] == 0) begin
            if (msat[i] == 1) ms[i] = 1;
            else begin mq[i] = mx[i]; mw[i] = 1; end
          end else mq[i] = mq[i] - 1;
        end
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic test_reset();
    compared++;
    if (dq[0] !== 4'd0 || dw[0] !== 1'b0 || ds[0] !== 1'b0) begin
      failed++;
      $display("FAIL reset_state: got q=%0d wrap=%b sat=%b want 0/0/0", dq[0], dw[0], ds[0]);
    end
    @(negedge clk);
    reset = 1'b0;
    en = 1'b1; up_dn = 1'b1;
    for (int k = 0; k < 5; k++) cycle();
    compared++;
    if (dq[0] !== 4'd5) begin
      failed++;
      $display("FAIL reset_precount: got q=%0d want 5", dq[0]);
    end
    #2 reset = 1'b1; up_dn = 1'b0;
    #1;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      compared++;
      if (dq[i] !== 4'd0 || dw[i] !== 1'b0 || ds[i] !== 1'b0 || dtc[i] !== 1'b1) begin
        failed++;
        $display("FAIL reset_async[%0d]: got q=%0d wrap=%b sat=%b tc=%b want 0/0/0/1",
                 i, dq[i], dw[i], ds[i], dtc[i]);
      end
    end
    reset = 1'b0; up_dn = 1'b1; en = 1'b1;
    cycle();
    compared++;
    if (dq[0] !== 4'd1) begin
      failed++;
      $display("FAIL reset_release: got q=%0d want 1", dq[0]);
    end
  endtask

  task automatic test_up_wrap();
    int exp_q[4] = '{8, 9, 0, 1};
    int exp_w[4] = '{0, 0, 1, 0};
    load = 1'b1; load_val = 4'd7; en = 1'b0; up_dn = 1'b1;
    cycle();
    load = 1'b0; en = 1'b1;
    for (int k = 0; k < 4; k++) begin
      cycle();
      compared++;
      if (dq[0] !== 4'(exp_q[k]) || dw[0] !== 1'(exp_w[k]) || dtc[0] !== 1'(exp_q[k] == 9)) begin
        failed++;
        $display("FAIL up_wrap step %0d: got q=%0d wrap=%b tc=%b want q=%0d wrap=%0d tc=%0d",
                 k, dq[0], dw[0], dtc[0], exp_q[k], exp_w[k], exp_q[k] == 9);
      end
    end
  endtask

  task automatic test_down_wrap();
    int exp_q[3] = '{0, 9, 8};
    int exp_w[3] = '{0, 1, 0};
    load = 1'b1; load_val = 4'd1; en = 1'b0; up_dn = 1'b0;
    cycle();
    load = 1'b0; en = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cycle();
      compared++;
      if (dq[0] !== 4'(exp_q[k]) || dw[0] !== 1'(exp_w[k]) || dtc[0] !== 1'(exp_q[k] == 0)) begin
        failed++;
        $display("FAIL down_wrap step %0d: got q=%0d wrap=%b tc=%b want q=%0d wrap=%0d tc=%0d",
                 k, dq[0], dw[0], dtc[0], exp_q[k], exp_w[k], exp_q[k] == 0);
      end
    end
  endtask

  task automatic test_saturate();
    int exp_s[3] = '{0, 1, 1};
    load = 1'b1; load_val = 4'd8; en = 1'b0; up_dn = 1'b1;
    cycle();
    load = 1'b0; en = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cycle();
      compared++;
      if (dq[1] !== 4'd9 || ds[1] !== 1'(exp_s[k]) || dw[1] !== 1'b0) begin
        failed++;
        $display("FAIL saturate step %0d: got q=%0d sat=%b wrap=%b want q=9 sat=%0d wrap=0",
                 k, dq[1], ds[1], dw[1], exp_s[k]);
      end
    end
    up_dn = 1'b0;
    cycle();
    compared++;
    if (dq[1] !== 4'd8 || ds[1] !== 1'b0) begin
      failed++;
      $display("FAIL saturate_leave: got q=%0d sat=%b want q=8 sat=0", dq[1], ds[1]);
    end
  endtask

  task automatic test_load_clamp();
    load = 1'b1; load_val = 4'd13; en = 1'b1; up_dn = 1'b1;
    cycle();
    compared++;
    if (dq[0] !== 4'd9 || dq[2] !== 4'd13 || dw[0] !== 1'b0) begin
      failed++;
      $display("FAIL load_clamp: got q9=%0d q15=%0d wrap=%b want 9/13/0", dq[0], dq[2], dw[0]);
    end
    load_val = 4'd3;
    cycle();
    compared++;
    if (dq[0] !== 4'd3 || dq[1] !== 4'd3) begin
      failed++;
      $display("FAIL load_plain: got q=%0d/%0d want 3", dq[0], dq[1]);
    end
  endtask

  task automatic test_full_range();
    load = 1'b1; load_val = 4'd0; en = 1'b0; up_dn = 1'b1;
    cycle();
    load = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      en = 1'b1;
      cycle();
      compared++;
      if (dq[2] !== 4'(k % 16) || dw[2] !== 1'(k == 16)) begin
        failed++;
        $display("FAIL full_range step %0d: got q=%0d wrap=%b want q=%0d wrap=%0d",
                 k, dq[2], dw[2], k % 16, k == 16);
      end
      if (k % 5 == 0) begin
        en = 1'b0;
        cycle();
        compared++;
        if (dq[2] !== 4'(k % 16) || dw[2] !== 1'b0) begin
          failed++;
          $display("FAIL full_range idle %0d: got q=%0d wrap=%b want q=%0d wrap=0",
                   k, dq[2], dw[2], k % 16);
        end
      end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      en       = ($urandom_range(3, 0) != 0);
      up_dn    = ($urandom_range(5, 0) < 4) ? 1'b1 : 1'b0;
      if (n % 50 >= 25) up_dn = ~up_dn;
      load     = ($urandom_range(9, 0) == 0);
      load_val = 4'($urandom_range(15, 0));
      cycle();
      for (int i = 0; i < 3; i++) begin
        compared++;
        if (dq[i] !== 4'(mq[i]) || dw[i] !== 1'(mw[i]) || ds[i] !== 1'(ms[i]) ||
            dtc[i] !== 1'(up_dn ? (mq[i] == mx[i]) : (mq[i] == 0))) begin
          failed++;
          $display("FAIL random[%0d] cyc %0d: got q=%0d wrap=%b sat=%b tc=%b want q=%0d wrap=%0d sat=%0d",
                   i, n, dq[i], dw[i], ds[i], dtc[i], mq[i], mw[i], ms[i]);
        end
      end
    end
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; up_dn = 1'b1; load = 1'b0; load_val = 4'd0;
    model_reset();
    #2;
    test_reset();
    test_up_wrap();
    test_down_wrap();
    test_saturate();
    test_load_clamp();
    test_full_range();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

endmodule
